// File: rtl/jk_drive_chk_pkg.sv
// Shared types and JK excitation encoding for the JK drive/check block.
package jk_drive_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // J/K drive pair
    typedef struct packed {
        logic j;
        logic k;
    } jk_t;

    // One slot of the expected-value pipeline
    typedef struct packed {
        logic vld;
        logic exp;
    } chk_t;

    // Excitation for each q transition (from -> to)
    localparam jk_t EXC_00 = '{j: 1'b0, k: 1'b0};
    localparam jk_t EXC_01 = '{j: 1'b1, k: 1'b0};
    localparam jk_t EXC_10 = '{j: 1'b0, k: 1'b1};
    localparam jk_t EXC_11 = '{j: 1'b0, k: 1'b0};

    // Drives that hold or clear the flop irrespective of history
    localparam jk_t JK_HOLD   = '{j: 1'b0, k: 1'b0};
    localparam jk_t JK_FORCE0 = '{j: 1'b0, k: 1'b1};

    // Pick the J/K pair that moves the flop from from_q to to_q
    function automatic jk_t excite(input logic from_q, input logic to_q);
        excite = EXC_00;
        case ({from_q, to_q})
            2'b00: excite = EXC_00;
            2'b01: excite = EXC_01;
            2'b10: excite = EXC_10;
            2'b11: excite = EXC_11;
        endcase
    endfunction

endpackage

// File: rtl/jk_drive_chk_fifo.sv
// Single-bit target FIFO; pointers carry an extra wrap bit for full/empty.
module jk_tgt_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_bit,
    input  logic pop,
    output logic pop_bit,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign pop_bit = mem[rptr[AW-1:0]];

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= push_bit;
        end
    end

    // Pointer advance on accepted push / pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/jk_drive_chk.sv
// Drives an external JK flop toward a queued target sequence and checks q.
module jk_drive_chk
    import jk_drive_chk_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tgt_valid,
    input  logic          tgt_bit,
    output logic          tgt_ready,
    input  logic          q_fb,
    output logic          j,
    output logic          k,
    output logic          busy,
    output logic          err,
    output logic [CW-1:0] err_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t state;
    state_t state_nx;

    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_bit;
    logic   push;
    logic   pop;

    logic   exp_q;
    logic   exp_nx;
    jk_t    jk_nx;
    chk_t   chk_nx;
    chk_t   stg1;
    chk_t   stg2;

    assign tgt_ready = ~fifo_full;
    assign push      = tgt_valid & tgt_ready;
    assign busy      = (state != ST_IDLE) && (~fifo_empty || stg1.vld || stg2.vld);

    jk_tgt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_bit (tgt_bit),
        .pop      (pop),
        .pop_bit  (fifo_bit),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: one INIT cycle once work arrives, then RUN indefinitely
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (!fifo_empty) state_nx = ST_INIT;
            ST_INIT: state_nx = ST_RUN;
            ST_RUN:  state_nx = ST_RUN;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Per-state pop decision, next drive, next expected q and pipeline entry
    always_comb begin
        pop    = 1'b0;
        jk_nx  = JK_HOLD;
        exp_nx = exp_q;
        chk_nx = '{vld: 1'b0, exp: 1'b0};
        case (state)
            ST_INIT: begin
                jk_nx  = JK_FORCE0;
                exp_nx = 1'b0;
                chk_nx = '{vld: 1'b1, exp: 1'b0};
            end
            ST_RUN: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    jk_nx  = excite(exp_q, fifo_bit);
                    exp_nx = fifo_bit;
                    chk_nx = '{vld: 1'b1, exp: fifo_bit};
                end
            end
            default: ;
        endcase
    end

    // Registered drive, tracked q and the two-stage expected-value pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            j     <= 1'b0;
            k     <= 1'b0;
            exp_q <= 1'b0;
            stg1  <= '0;
            stg2  <= '0;
        end else begin
            j     <= jk_nx.j;
            k     <= jk_nx.k;
            exp_q <= exp_nx;
            stg1  <= chk_nx;
            stg2  <= stg1;
        end
    end

    // Compare feedback against the matured expectation; sticky flag, saturating count
    always_ff @(posedge clk) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (stg2.vld && (q_fb != stg2.exp)) begin
            err <= 1'b1;
            if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_jk_drive_chk.sv
// Self-checking bench: behavioural JK flop, cycle model of the drive/check rules.
module tb_jk_drive_chk;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tgt_valid = 1'b0;
    logic       tgt_bit = 1'b0;
    logic       inv = 1'b0;

    logic       tgt_ready, j, k, busy, err;
    logic [7:0] err_cnt;
    logic       tgt_ready2, j2, k2, busy2, err2;
    logic [1:0] err_cnt2;

    logic       q = 1'b1;
    logic       q2 = 1'b1;
    logic       q_fb, q_fb2;

    logic       f_rst = 1'b1;
    logic       f_want = 1'b0;
    logic       f_bit = 1'b0;
    logic       f_pop = 1'b0;
    logic       f_push, f_out, f_full, f_empty;

    int checks = 0;
    int errors = 0;

    // model state
    bit  mq[$];
    int  ph = 0;
    bit  mj, mk, mexp;
    bit  dv0, dv1, de0, de1;
    bit  merr;
    int  mcnt, mcnt2;
    bit  live = 1'b0;
    int  sz;
    bit  t;

    logic [1:0] jk_log [10];
    logic       q_log  [10];

    logic       s1_bits [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] s1_jk   [5]  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    logic       s1_q    [5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       s36_bits[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       s38_bits[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       ff_bits [6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    assign q_fb   = q ^ inv;
    assign q_fb2  = q2 ^ inv;
    assign f_push = f_want & ~f_full;

    jk_drive_chk #(.DEPTH(DEPTH), .CW(8)) u_dut (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready), .q_fb(q_fb), .j(j), .k(k), .busy(busy),
        .err(err), .err_cnt(err_cnt)
    );

    jk_drive_chk #(.DEPTH(DEPTH), .CW(2)) u_dut2 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready2), .q_fb(q_fb2), .j(j2), .k(k2), .busy(busy2),
        .err(err2), .err_cnt(err_cnt2)
    );

    jk_tgt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(f_rst), .push(f_push), .push_bit(f_bit), .pop(f_pop),
        .pop_bit(f_out), .full(f_full), .empty(f_empty)
    );

    // Behavioural JK flops driven by each DUT
    always @(posedge clk) begin
        q  <= (j & ~q) | (~k & q);
        q2 <= (j2 & ~q2) | (~k2 & q2);
    end

    task automatic chk_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Cycle model: queue of targets, start-up phases, and a 2-deep expectation delay line
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            ph = 0; mj = 0; mk = 0; mexp = 0;
            dv0 = 0; dv1 = 0; de0 = 0; de1 = 0;
            merr = 0; mcnt = 0; mcnt2 = 0;
            live = 1'b1;
        end else if (live) begin
            sz = mq.size();
            if (dv1 && (q_fb !== de1)) begin
                merr = 1'b1;
                if (mcnt < 255) mcnt++;
                if (mcnt2 < 3) mcnt2++;
            end
            dv1 = dv0;
            de1 = de0;
            case (ph)
                0: begin
                    mj = 0; mk = 0; dv0 = 0; de0 = 0;
                    if (sz > 0) ph = 1;
                end
                1: begin
                    mj = 0; mk = 1; mexp = 0; dv0 = 1; de0 = 0; ph = 2;
                end
                default: begin
                    if (sz > 0) begin
                        t = mq.pop_front();
                        mj = ~mexp & t;
                        mk = mexp & ~t;
                        mexp = t;
                        dv0 = 1; de0 = t;
                    end else begin
                        mj = 0; mk = 0; dv0 = 0; de0 = 0;
                    end
                end
            endcase
            if (tgt_valid && sz < int'(DEPTH)) mq.push_back(tgt_bit);
        end
    end

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (live) begin
            chk_b("j", j, mj);
            chk_b("k", k, mk);
            chk_b("tgt_ready", tgt_ready, mq.size() < int'(DEPTH));
            chk_b("busy", busy, (ph != 0) && (mq.size() > 0 || dv0 || dv1));
            chk_b("err", err, merr);
            chk_i("err_cnt", int'(err_cnt), mcnt);
            chk_b("j2", j2, mj);
            chk_b("k2", k2, mk);
            chk_b("err2", err2, merr);
            chk_i("err_cnt2", int'(err_cnt2), mcnt2);
        end
    end

    task automatic do_reset();
        rst = 1'b1; tgt_valid = 1'b0; inv = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk_b("rst_ready", tgt_ready, 1'b1);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_j", j, 1'b0);
        chk_b("rst_k", k, 1'b0);
        chk_b("rst_err", err, 1'b0);
        chk_i("rst_cnt", int'(err_cnt), 0);

        // back-to-back 0,1,1,0
        for (int i = 0; i < 8; i++) begin
            tgt_valid = (i < 4);
            tgt_bit   = (i < 4) ? s1_bits[i] : 1'b0;
            tick();
            jk_log[i] = {j, k};
            q_log[i]  = q;
        end
        tgt_valid = 1'b0;
        for (int i = 0; i < 5; i++) chk_i("s1_jk", int'(jk_log[i+2]), int'(s1_jk[i]));
        for (int i = 0; i < 5; i++) chk_b("s1_q", q_log[i+3], s1_q[i]);
        tick(); tick();
        chk_b("s1_err", err, 1'b0);
        chk_b("s1_busy_done", busy, 1'b0);

        // single inverted compare on an expected 0
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tgt_valid = (i < 4);
            tgt_bit   = 1'b0;
            inv       = (i == 5);
            tick();
            if (i == 5) begin
                chk_b("s35_err_now", err, 1'b1);
                chk_i("s35_cnt_now", int'(err_cnt), 1);
            end
        end
        inv = 1'b0;
        chk_b("s35_err_hold", err, 1'b1);
        chk_i("s35_cnt_hold", int'(err_cnt), 1);

        // stuck-inverted feedback for six compares
        do_reset();
        inv = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tgt_valid = (i < 5);
            tgt_bit   = (i < 5) ? s36_bits[i] : 1'b0;
            tick();
        end
        inv = 1'b0;
        chk_i("s36_cnt2_sat", int'(err_cnt2), 3);
        chk_i("s36_cnt8", int'(err_cnt), 6);
        tick();
        chk_i("s36_cnt2_hold", int'(err_cnt2), 3);

        // push 1, three idle cycles, push 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tgt_valid = (i == 0) || (i == 4);
            tgt_bit   = (i == 0);
            tick();
            jk_log[i] = {j, k};
            q_log[i]  = q;
        end
        tgt_valid = 1'b0;
        chk_i("s37_gap_jk", int'(jk_log[4]), 0);
        chk_i("s37_fall_jk", int'(jk_log[5]), 1);
        chk_b("s37_q_hi", q_log[4], 1'b1);
        chk_b("s37_q_hold", q_log[5], 1'b1);
        chk_b("s37_q_lo", q_log[6], 1'b0);
        chk_b("s37_err", err, 1'b0);

        // reset with three queued and two compares in flight
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tgt_valid = 1'b1;
            tgt_bit   = s38_bits[i];
            tick();
        end
        chk_b("s38_busy_pre", busy, 1'b1);
        rst = 1'b1; tgt_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk_b("s38_ready", tgt_ready, 1'b1);
        chk_b("s38_busy", busy, 1'b0);
        chk_b("s38_j", j, 1'b0);
        chk_b("s38_k", k, 1'b0);
        chk_b("s38_err", err, 1'b0);
        tick(); tick();

        // FIFO alone: fill without popping, refuse extras, drain in order
        f_rst = 1'b1;
        tick();
        f_rst = 1'b0;
        chk_b("ff_empty0", f_empty, 1'b1);
        chk_b("ff_full0", f_full, 1'b0);
        for (int i = 0; i < 6; i++) begin
            f_want = 1'b1;
            f_bit  = ff_bits[i];
            tick();
            chk_b("ff_full", f_full, i >= 3);
        end
        f_want = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_b("ff_data", f_out, ff_bits[i]);
            f_pop = 1'b1;
            tick();
            f_pop = 1'b0;
        end
        chk_b("ff_empty_end", f_empty, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
